fixed_point_divider: RTL
========================

# fixed_point_divider

Sequential signed Q16.16 divider computing `q_out = a_in / b_in`, the inverse operation of the team's combinational fixed-point multiplier. It uses the same number format, saturation semantics and overflow reporting. It is an iterative restoring divider with a start/done handshake, so one divider is shared by consumers that can tolerate multi-cycle latency, such as normalisation and reciprocal paths. Results truncate toward zero and saturate on overflow or divide-by-zero.

## Interface
- `WIDTH`, 32, total word width of operands and result (two's complement).
- `FRAC_BITS`, 16, fractional bits; format is Q(WIDTH-FRAC_BITS).FRAC_BITS.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset. One clock domain; reset polarity and synchronicity are fixed.
- `start`  input  1  request; sampled on a rising edge only while idle.
- `a_in`  input  WIDTH  signed dividend, captured on the accepting edge.
- `b_in`  input  WIDTH  signed divisor, captured on the accepting edge.
- `q_out`  output  WIDTH  signed quotient, registered; holds until the next result is written.
- `overflow`  output  1  result saturated; held with `q_out`.
- `div_by_zero`  output  1  divisor was zero; held with `q_out`.
- `busy`  output  1  operation in progress; `start` is ignored while high.
- `done`  output  1  one-cycle pulse marking the cycle in which new `q_out` and flags are valid.

## Operation
- States: IDLE, CALC, FINISH.
- IDLE, `start`=1, `b_in`!=0 → CALC. On the accepting edge the block:
  - latches sign = `a_in[MSB]` XOR `b_in[MSB]`;
  - latches |a| and |b| as WIDTH+1-bit magnitudes, so -2^31 is exact;
  - loads dividend register = |a| << FRAC_BITS (WIDTH+FRAC_BITS bits);
  - clears the partial remainder and sets `busy`.
- IDLE, `start`=1, `b_in`==0 → FINISH directly, with `div_by_zero` pending.
- CALC: one restoring step per cycle, WIDTH+FRAC_BITS = 48 iterations.
  - Shift the next dividend bit into the remainder.
  - If remainder ≥ |b|, subtract |b| and shift in quotient bit 1; otherwise shift in 0.
  - An iteration counter runs 0..47; after the last step → FINISH.
- FINISH, single cycle. It writes `q_out`, `overflow` and `div_by_zero`, pulses `done`, clears `busy`, then → IDLE.
  - Normal case: magnitude M (48 bits).
    - If sign=0 and M > 2^31-1: `q_out`=0x7FFFFFFF, `overflow`=1.
    - If sign=1 and M > 2^31: `q_out`=0x80000000, `overflow`=1.
    - Otherwise `q_out` = sign ? -M : M, truncated to WIDTH bits, `overflow`=0.
  - Divide-by-zero case: `q_out` = `a_in[MSB]` ? 0x80000000 : 0x7FFFFFFF, `overflow`=1, `div_by_zero`=1. This includes 0/0, which gives 0x7FFFFFFF.
- Rounding is truncation toward zero. The remainder is discarded and not output.
- `start` while `busy`=1 is ignored, with no queueing. Changes on `a_in`/`b_in` after acceptance have no effect.
- Outputs are not cleared on `start`. The previous result stays visible until the new FINISH write.

## Timing
- Reset (asynchronous, `rst_n`=0):
  - `q_out`=0, `overflow`=0, `div_by_zero`=0, `busy`=0, `done`=0, state=IDLE.
  - Iteration counter and datapath registers are cleared.
- Reset asserted mid-operation aborts the operation immediately. No `done` pulse follows. After release the block is IDLE.
- Normal divide, with the accepting edge as edge 0:
  - `busy`=1 from after edge 0.
  - CALC on edges 1..48.
  - FINISH write on edge 49, so `done`=1 and `busy`=0 in the cycle after edge 49. `done` drops after edge 50.
  - Latency: WIDTH+FRAC_BITS+1 = 49 cycles.
- Divide-by-zero: FINISH on edge 1, so `done` is high in the cycle after edge 1 (latency 1). `busy` is high for exactly one cycle.
- Back-to-back operation: `start` held high during the `done` cycle is accepted on the next edge, since the block is already IDLE. Sustained throughput is one result per 50 cycles.
- `start` sampled in the same cycle as FINISH is ignored, because the state is not yet IDLE.

## Test plan
- Reset, then 6.0/3.0 (`a_in`=0x00060000, `b_in`=0x00030000), pulse `start` → `done` exactly 49 cycles later, `q_out`=0x00020000, both flags 0, `busy` high only in between.
- Sign and truncation cases, each with flags 0:
  - -6.0/3.0 (0xFFFA0000/0x00030000) → 0xFFFE0000;
  - 1.0/3.0 (0x00010000/0x00030000) → 0x00005555;
  - -1.0/3.0 (0xFFFF0000/0x00030000) → 0xFFFFAAAB;
  - -1.0/-0.5 (0xFFFF0000/0xFFFF8000) → 0x00020000.
- Overflow cases:
  - 32767.0/0.5 (0x7FFF0000/0x00008000) → 0x7FFFFFFF, `overflow`=1;
  - -32768.0/-1.0 (0x80000000/0xFFFF0000) → 0x7FFFFFFF, `overflow`=1;
  - -32768.0/1.0 (0x80000000/0x00010000) → 0x80000000, `overflow`=0.
- Divide-by-zero cases:
  - 2.0/0 → `done` 1 cycle after the accepting edge, `q_out`=0x7FFFFFFF, `overflow`=1, `div_by_zero`=1;
  - -2.0/0 → `q_out`=0x80000000, both flags 1.
- Handshake checks:
  - pulse `start` with new operands at cycle 10 of a busy operation → ignored; the original result is delivered at cycle 49;
  - hold `start` high continuously → the second result's `done` arrives 50 cycles after the first.
- Assert `rst_n`=0 at cycle 20 of an operation, release 3 cycles later → all outputs 0 immediately, no `done`. A subsequent 2.0/3.0 divide returns 0x0000AAAA.

Source files
------------

// File: rtl/fixed_point_divider.sv
// Sequential signed Q(WIDTH-FRAC_BITS).FRAC_BITS divider. It uses a restoring algorithm with one quotient bit per cycle.
// It has a start/done handshake and saturates on overflow or on a zero divisor.
module fixed_point_divider #(
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] q_out,
  output logic             overflow,
  output logic             div_by_zero,
  output logic             busy,
  output logic             done
);

  localparam int DW = WIDTH + FRAC_BITS;
  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST_ITER = CW'(DW - 1);
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_sign;
  logic              r_dz;
  logic [WIDTH:0]    r_b_mag;
  logic [WIDTH:0]    r_rem;
  logic [DW-1:0]     r_dividend;
  logic [DW-1:0]     r_quot;
  logic [CW-1:0]     r_cnt;

  logic [WIDTH-1:0]  w_a_mag;
  logic [WIDTH-1:0]  w_b_mag;
  logic              w_b_zero;
  logic [WIDTH+1:0]  w_rem_shift;
  logic [WIDTH+1:0]  w_rem_diff;
  logic              w_ge;
  logic              w_big_pos;
  logic              w_big_neg;
  logic [WIDTH-1:0]  w_q_fin;
  logic              w_ovf_fin;

  // An unsigned WIDTH-bit magnitude holds 2^(WIDTH-1) exactly, so the most negative operand is not a special case.
  assign w_a_mag  = a_in[WIDTH-1] ? (~a_in + 1'b1) : a_in;
  assign w_b_mag  = b_in[WIDTH-1] ? (~b_in + 1'b1) : b_in;
  assign w_b_zero = (b_in == '0);

  // The borrow out of the trial subtraction doubles as the compare result.
  assign w_rem_shift = {r_rem, r_dividend[DW-1]};
  assign w_rem_diff  = w_rem_shift - {1'b0, r_b_mag};
  assign w_ge        = ~w_rem_diff[WIDTH+1];

  assign w_big_pos = |r_quot[DW-1:WIDTH-1];
  assign w_big_neg = (|r_quot[DW-1:WIDTH]) | (r_quot[WIDTH-1] & (|r_quot[WIDTH-2:0]));

  always_comb begin
    w_q_fin   = '0;
    w_ovf_fin = 1'b0;
    if (r_dz) begin
      w_q_fin   = r_sign ? MIN_NEG : MAX_POS;
      w_ovf_fin = 1'b1;
    end else if (!r_sign && w_big_pos) begin
      w_q_fin   = MAX_POS;
      w_ovf_fin = 1'b1;
    end else if (r_sign && w_big_neg) begin
      w_q_fin   = MIN_NEG;
      w_ovf_fin = 1'b1;
    end else begin
      w_q_fin = r_sign ? (~r_quot[WIDTH-1:0] + 1'b1) : r_quot[WIDTH-1:0];
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = w_b_zero ? FINISH : CALC;
      CALC:    if (r_cnt == LAST_ITER) w_state_next = FINISH;
      FINISH:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign      <= 1'b0;
      r_dz        <= 1'b0;
      r_b_mag     <= '0;
      r_rem       <= '0;
      r_dividend  <= '0;
      r_quot      <= '0;
      r_cnt       <= '0;
      q_out       <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            // With a zero divisor this sign equals the dividend sign, which picks the saturation direction.
            r_sign     <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
            r_dz       <= w_b_zero;
            r_b_mag    <= {1'b0, w_b_mag};
            r_dividend <= {w_a_mag, {FRAC_BITS{1'b0}}};
            r_rem      <= '0;
            r_quot     <= '0;
            r_cnt      <= '0;
            busy       <= 1'b1;
          end
        end
        CALC: begin
          r_rem      <= w_ge ? w_rem_diff[WIDTH:0] : w_rem_shift[WIDTH:0];
          r_quot     <= {r_quot[DW-2:0], w_ge};
          r_dividend <= {r_dividend[DW-2:0], 1'b0};
          r_cnt      <= r_cnt + 1'b1;
        end
        FINISH: begin
          q_out       <= w_q_fin;
          overflow    <= w_ovf_fin;
          div_by_zero <= r_dz;
          done        <= 1'b1;
          busy        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
